// File: rtl/mem_wb_elastic_pkg.sv
// rtl/mem_wb_elastic_pkg.sv - shared constants and occupancy encoding for the MEM->WB boundary
package mem_wb_elastic_pkg;
    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam int          RegBus       = 32;
    localparam int          RegAddrBus   = 5;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'd0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;
endpackage

// File: rtl/mem_wb_slot.sv
// rtl/mem_wb_slot.sv - one payload register (valid + bundle) with load, async reset and sync clear
module mem_wb_slot
    import mem_wb_elastic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Sync clear only drops valid; payload keeps its last value for the output hold rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/mem_wb_elastic.sv
// rtl/mem_wb_elastic.sv - elastic MEM->WB boundary with 2-entry skid; HI/LO path under MEMWB_HILO_EN
module mem_wb_elastic
    import mem_wb_elastic_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_CH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
    input  logic [NUM_CH-1:0]        mem_wreg,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
`ifdef MEMWB_HILO_EN
    input  logic                     mem_whilo,
    input  logic [DATA_W-1:0]        mem_hi,
    input  logic [DATA_W-1:0]        mem_lo,
    output logic                     wb_whilo,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*ADDR_W-1:0] wb_wd,
    output logic [NUM_CH-1:0]        wb_wreg,
    output logic [NUM_CH*DATA_W-1:0] wb_wdata,
    output logic [1:0]               occupancy
);

    localparam int WREG_LO  = NUM_CH * ADDR_W;
    localparam int WDATA_LO = WREG_LO + NUM_CH;
    localparam int REG_W    = WDATA_LO + NUM_CH * DATA_W;
`ifdef MEMWB_HILO_EN
    localparam int PW = REG_W + 1 + 2 * DATA_W;
`else
    localparam int PW = REG_W;
`endif

    logic [NUM_CH-1:0] wreg_cap;
    logic [PW-1:0]     in_payload;
    logic [PW-1:0]     main_d;
    logic [PW-1:0]     main_q;
    logic [PW-1:0]     skid_q;
    logic              main_valid;
    logic              skid_valid;
    logic              main_load;
    logic              main_clr;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clr;
    logic              accept;
    logic              deliver;
    occ_e              state;

    // r0 is hard-wired: its enable is dropped at capture, data still travels.
    always_comb begin
        wreg_cap = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wreg_cap[c] = mem_wreg[c] & (mem_wd[c*ADDR_W +: ADDR_W] != ADDR_W'(NOPRegAddr));
        end
    end

`ifdef MEMWB_HILO_EN
    assign in_payload = {mem_whilo, mem_hi, mem_lo, mem_wdata, wreg_cap, mem_wd};
`else
    assign in_payload = {mem_wdata, wreg_cap, mem_wd};
`endif

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign deliver   = main_valid & out_ready;

    always_comb begin
        state = main_valid ? (skid_valid ? OCC_FULL : OCC_ONE) : OCC_EMPTY;
    end

    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        case (state)
            OCC_EMPTY: main_load = accept;
            OCC_ONE: begin
                if (deliver) begin
                    main_load = accept;
                    main_clr  = !accept;
                end else begin
                    skid_load = accept;
                end
            end
            OCC_FULL: begin
                if (deliver) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                end
            end
            default: begin
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end
        endcase
        // Flush wins over everything; a coincident delivery is already owned by WB.
        if (flush) begin
            main_load = 1'b0;
            skid_load = 1'b0;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_payload;

    mem_wb_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clr   (main_clr),
        .load  (main_load),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    mem_wb_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr   (skid_clr),
        .load  (skid_load),
        .d     (in_payload),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign wb_wd     = main_q[0 +: NUM_CH*ADDR_W];
    assign wb_wreg   = main_valid ? main_q[WREG_LO +: NUM_CH] : {NUM_CH{WriteDisable}};
    assign wb_wdata  = main_q[WDATA_LO +: NUM_CH*DATA_W];
    assign occupancy = state;

`ifdef MEMWB_HILO_EN
    assign wb_lo    = main_q[REG_W +: DATA_W];
    assign wb_hi    = main_q[REG_W+DATA_W +: DATA_W];
    assign wb_whilo = main_q[PW-1] & main_valid;
`endif

endmodule

// File: tb/tb_mem_wb_elastic.sv
// tb/tb_mem_wb_elastic.sv - directed self-checking bench for mem_wb_elastic (HI/LO test under MEMWB_HILO_EN)
module tb_mem_wb_elastic;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef MEMWB_HILO_EN
    localparam int NCH = 2;
`else
    localparam int NCH = 1;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [NCH*ADDR_W-1:0] mem_wd = '0;
    logic [NCH-1:0]        mem_wreg = '0;
    logic [NCH*DATA_W-1:0] mem_wdata = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [NCH*ADDR_W-1:0] wb_wd;
    logic [NCH-1:0]        wb_wreg;
    logic [NCH*DATA_W-1:0] wb_wdata;
    logic [1:0]            occupancy;
`ifdef MEMWB_HILO_EN
    logic                  mem_whilo = 1'b0;
    logic [DATA_W-1:0]     mem_hi = '0;
    logic [DATA_W-1:0]     mem_lo = '0;
    logic                  wb_whilo;
    logic [DATA_W-1:0]     wb_hi;
    logic [DATA_W-1:0]     wb_lo;
`endif

    int npass = 0;
    int nchk  = 0;

    always #5 clk = ~clk;

    mem_wb_elastic #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
`ifdef MEMWB_HILO_EN
        .mem_whilo (mem_whilo),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
        .wb_whilo  (wb_whilo),
        .wb_hi     (wb_hi),
        .wb_lo     (wb_lo),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .occupancy (occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] wd, input logic wreg,
                         input logic [DATA_W-1:0] wdata);
        in_valid  = v;
        mem_wd    = '0;
        mem_wreg  = '0;
        mem_wdata = '0;
        mem_wd[ADDR_W-1:0]    = wd;
        mem_wreg[0]           = wreg;
        mem_wdata[DATA_W-1:0] = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        nchk++; if (occupancy !== 2'd0) $display("FAIL reset_occ got %0d exp 0", occupancy); else npass++;
        nchk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else npass++;
        nchk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else npass++;
        rst = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 32'h0000_0011);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        nchk++; if (out_valid !== 1'b1 || wb_wd[ADDR_W-1:0] !== 5'd3)
            $display("FAIL reset_pre_bundle got v=%b wd=%0d exp v=1 wd=3", out_valid, wb_wd[ADDR_W-1:0]); else npass++;
        #2 rst = 1'b1;
        #1;
        nchk++; if (out_valid !== 1'b0) $display("FAIL reset_async_valid got %b exp 0", out_valid); else npass++;
        nchk++; if (wb_wreg !== '0) $display("FAIL reset_async_wreg got %b exp 0", wb_wreg); else npass++;
        nchk++; if (wb_wd !== '0) $display("FAIL reset_async_wd got %0h exp 0", wb_wd); else npass++;
        nchk++; if (wb_wdata !== '0) $display("FAIL reset_async_wdata got %0h exp 0", wb_wdata); else npass++;
        nchk++; if (in_ready !== 1'b1 || occupancy !== 2'd0)
            $display("FAIL reset_async_ctrl got rdy=%b occ=%0d exp rdy=1 occ=0", in_ready, occupancy); else npass++;
`ifdef MEMWB_HILO_EN
        nchk++; if (wb_whilo !== 1'b0 || wb_hi !== '0 || wb_lo !== '0)
            $display("FAIL reset_async_hilo got w=%b hi=%0h lo=%0h exp 0", wb_whilo, wb_hi, wb_lo); else npass++;
`endif
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            drive(1'b1, 5'(n), 1'b1, 32'hA5A5_0000 + 32'(n));
            step();
            nchk++; if (out_valid !== 1'b1 || occupancy !== 2'd1)
                $display("FAIL stream_valid n=%0d got v=%b occ=%0d exp v=1 occ=1", n, out_valid, occupancy); else npass++;
            nchk++; if (wb_wd[ADDR_W-1:0] !== 5'(n) || wb_wreg[0] !== 1'b1)
                $display("FAIL stream_addr n=%0d got wd=%0d wreg=%b exp wd=%0d wreg=1", n, wb_wd[ADDR_W-1:0], wb_wreg[0], n); else npass++;
            nchk++; if (wb_wdata[DATA_W-1:0] !== 32'hA5A5_0000 + 32'(n))
                $display("FAIL stream_data n=%0d got %h exp %h", n, wb_wdata[DATA_W-1:0], 32'hA5A5_0000 + 32'(n)); else npass++;
        end
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        step();
        nchk++; if (out_valid !== 1'b0 || wb_wreg !== '0 || occupancy !== 2'd0)
            $display("FAIL stream_drain got v=%b wreg=%b occ=%0d exp 0/0/0", out_valid, wb_wreg, occupancy); else npass++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 5'd9, 1'b1, 32'h0000_0100);
        step();
        nchk++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || wb_wd[ADDR_W-1:0] !== 5'd9)
            $display("FAIL bp_one got occ=%0d rdy=%b wd=%0d exp 1/1/9", occupancy, in_ready, wb_wd[ADDR_W-1:0]); else npass++;
        drive(1'b1, 5'd10, 1'b1, 32'h0000_0200);
        step();
        nchk++; if (occupancy !== 2'd2 || in_ready !== 1'b0)
            $display("FAIL bp_full got occ=%0d rdy=%b exp 2/0", occupancy, in_ready); else npass++;
        nchk++; if (wb_wd[ADDR_W-1:0] !== 5'd9 || wb_wdata[DATA_W-1:0] !== 32'h100)
            $display("FAIL bp_hold1 got wd=%0d data=%h exp 9/100", wb_wd[ADDR_W-1:0], wb_wdata[DATA_W-1:0]); else npass++;
        drive(1'b1, 5'd11, 1'b1, 32'h0000_0300);
        step();
        nchk++; if (occupancy !== 2'd2 || wb_wd[ADDR_W-1:0] !== 5'd9 || wb_wdata[DATA_W-1:0] !== 32'h100)
            $display("FAIL bp_hold2 got occ=%0d wd=%0d data=%h exp 2/9/100", occupancy, wb_wd[ADDR_W-1:0], wb_wdata[DATA_W-1:0]); else npass++;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        out_ready = 1'b1;
        step();
        nchk++; if (out_valid !== 1'b1 || occupancy !== 2'd1 || wb_wd[ADDR_W-1:0] !== 5'd10 || wb_wdata[DATA_W-1:0] !== 32'h200)
            $display("FAIL bp_second got v=%b occ=%0d wd=%0d data=%h exp 1/1/10/200", out_valid, occupancy, wb_wd[ADDR_W-1:0], wb_wdata[DATA_W-1:0]); else npass++;
        step();
        nchk++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL bp_no_dup got v=%b occ=%0d exp 0/0", out_valid, occupancy); else npass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 5'd12, 1'b1, 32'h0000_0C0C);
        step();
        drive(1'b1, 5'd13, 1'b1, 32'h0000_0D0D);
        step();
        nchk++; if (occupancy !== 2'd2) $display("FAIL flush_prefill got occ=%0d exp 2", occupancy); else npass++;
        flush = 1'b1;
        drive(1'b1, 5'd14, 1'b1, 32'h0000_0444);
        step();
        flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        nchk++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || wb_wreg !== '0 || in_ready !== 1'b1)
            $display("FAIL flush_clear got v=%b occ=%0d wreg=%b rdy=%b exp 0/0/0/1", out_valid, occupancy, wb_wreg, in_ready); else npass++;
        nchk++; if (wb_wd[ADDR_W-1:0] !== 5'd12)
            $display("FAIL flush_addr_hold got wd=%0d exp 12", wb_wd[ADDR_W-1:0]); else npass++;
        out_ready = 1'b1;
        step();
        nchk++; if (out_valid !== 1'b0 || wb_wdata[DATA_W-1:0] === 32'h444)
            $display("FAIL flush_drop got v=%b data=%h exp v=0 and not 444", out_valid, wb_wdata[DATA_W-1:0]); else npass++;
    endtask

    task automatic test_r0();
        out_ready = 1'b1;
        drive(1'b1, 5'd0, 1'b1, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        nchk++; if (out_valid !== 1'b1 || wb_wreg[0] !== 1'b0)
            $display("FAIL r0_wreg got v=%b wreg=%b exp v=1 wreg=0", out_valid, wb_wreg[0]); else npass++;
        nchk++; if (wb_wdata[DATA_W-1:0] !== 32'hDEAD_BEEF)
            $display("FAIL r0_data got %h exp deadbeef", wb_wdata[DATA_W-1:0]); else npass++;
        step();
    endtask

`ifdef MEMWB_HILO_EN
    task automatic test_hilo();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mem_wd    = {5'd2, 5'd1};
        mem_wreg  = 2'b11;
        mem_wdata = {32'h2222_0002, 32'h1111_0001};
        mem_whilo = 1'b1;
        mem_hi    = 32'h1234_5678;
        mem_lo    = 32'h9ABC_DEF0;
        nchk++; if (wb_whilo !== 1'b0) $display("FAIL hilo_idle got %b exp 0", wb_whilo); else npass++;
        step();
        in_valid  = 1'b0;
        mem_whilo = 1'b0;
        nchk++; if (out_valid !== 1'b1 || wb_whilo !== 1'b1 || wb_hi !== 32'h1234_5678 || wb_lo !== 32'h9ABC_DEF0)
            $display("FAIL hilo_bundle got v=%b w=%b hi=%h lo=%h", out_valid, wb_whilo, wb_hi, wb_lo); else npass++;
        nchk++; if (wb_wd !== {5'd2, 5'd1} || wb_wreg !== 2'b11 || wb_wdata !== {32'h2222_0002, 32'h1111_0001})
            $display("FAIL hilo_channels got wd=%h wreg=%b data=%h", wb_wd, wb_wreg, wb_wdata); else npass++;
        step();
        nchk++; if (out_valid !== 1'b0 || wb_whilo !== 1'b0)
            $display("FAIL hilo_bubble got v=%b w=%b exp 0/0", out_valid, wb_whilo); else npass++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_r0();
`ifdef MEMWB_HILO_EN
        test_hilo();
`endif
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
